// File: rtl/key_sweep_evaluator.sv
// Sweeps every input pattern through a locked netlist and its oracle using one
// candidate key, counting patterns where the two responses disagree.
module key_sweep_evaluator #(
    parameter int W      = 8,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] key,
    input  logic         locked_out,
    input  logic         golden_out,
    output logic [W-1:0] stim_inputs,
    output logic [W-1:0] stim_key,
    output logic         busy,
    output logic         done,
    output logic [W:0]   err_count,
    output logic         first_err_valid,
    output logic [W-1:0] first_err_pat,
    output logic         key_correct
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [W-1:0] LAST_PAT = {W{1'b1}};

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t        state;
    logic [CW-1:0] settle_cnt;
    logic          mism;
    logic [W:0]    err_next;

    assign mism     = locked_out ^ golden_out;
    // Next count is used on the final sample so key_correct lines up with done.
    assign err_next = err_count + {{W{1'b0}}, mism};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= '0;
            stim_inputs     <= '0;
            stim_key        <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_pat   <= '0;
            key_correct     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        stim_key        <= key;
                        stim_inputs     <= '0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_pat   <= '0;
                        key_correct     <= 1'b0;
                        settle_cnt      <= '0;
                        busy            <= 1'b1;
                        state           <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == CW'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                SAMPLE: begin
                    err_count <= err_next;
                    if (mism && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_pat   <= stim_inputs;
                    end
                    if (stim_inputs == LAST_PAT) begin
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        key_correct <= (err_next == '0);
                        state       <= DONE;
                    end else begin
                        stim_inputs <= stim_inputs + W'(1);
                        state       <= DRIVE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_sweep_evaluator.sv
// Self-checking bench for key_sweep_evaluator: table sweeps, random mismatch
// maps scored by a pattern-level model, and reset/hold/settle corner cases.
module tb_key_sweep_evaluator;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, sel;
    logic [W-1:0] key;
    logic [1:0]   mode;
    logic [255:0] fmap;

    logic start1, start2;
    assign start1 = start & ~sel;
    assign start2 = start & sel;

    logic         lo1, go1, busy1, done1, fv1, kc1;
    logic [W-1:0] si1, sk1, fp1;
    logic [W:0]   ec1;
    logic         lo2, go2, busy2, done2, fv2, kc2;
    logic [W-1:0] si2, sk2, fp2;
    logic [W:0]   ec2;

    // Oracle is a parity function; the locked model flips it per mode.
    assign go1 = ^si1;
    assign lo1 = go1 ^ ((mode == 2'd0) ? ((si1 == sk1) && (sk1 != 8'hA5)) :
                        (mode == 2'd1) ? 1'b1 : fmap[si1]);
    assign go2 = ^si2;
    assign lo2 = go2 ^ ((mode == 2'd0) ? ((si2 == sk2) && (sk2 != 8'hA5)) :
                        (mode == 2'd1) ? 1'b1 : fmap[si2]);

    key_sweep_evaluator #(.W(W), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .key(key),
        .locked_out(lo1), .golden_out(go1), .stim_inputs(si1), .stim_key(sk1),
        .busy(busy1), .done(done1), .err_count(ec1), .first_err_valid(fv1),
        .first_err_pat(fp1), .key_correct(kc1));

    key_sweep_evaluator #(.W(W), .SETTLE(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .key(key),
        .locked_out(lo2), .golden_out(go2), .stim_inputs(si2), .stim_key(sk2),
        .busy(busy2), .done(done2), .err_count(ec2), .first_err_valid(fv2),
        .first_err_pat(fp2), .key_correct(kc2));

    logic         m_busy, m_done, m_fv, m_kc;
    logic [W-1:0] m_si, m_sk, m_fp;
    logic [W:0]   m_ec;
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;
    assign m_fv   = sel ? fv2 : fv1;
    assign m_kc   = sel ? kc2 : kc1;
    assign m_si   = sel ? si2 : si1;
    assign m_sk   = sel ? sk2 : sk1;
    assign m_fp   = sel ? fp2 : fp1;
    assign m_ec   = sel ? ec2 : ec1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Runs one sweep on the selected instance; returns the done cycle (-1 on
    // timeout) and whether pattern timing, busy and stim_key held throughout.
    task automatic run_sweep(input logic [W-1:0] k, input int settle, input bit hold,
                             output int done_cyc, output bit tim_ok);
        logic [W-1:0] prev;
        int limit;
        limit    = 256 * (settle + 1) + 20;
        done_cyc = -1;
        tim_ok   = 1'b1;
        prev     = '0;
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            key = 8'($urandom);
            if (m_done) begin
                done_cyc = cyc;
                if (m_busy || m_sk !== k || m_si !== 8'hFF) tim_ok = 1'b0;
                break;
            end
            if (!m_busy || m_sk !== k) tim_ok = 1'b0;
            if (cyc == 1) begin
                if (m_si !== 8'h00) tim_ok = 1'b0;
            end else if (m_si !== prev) begin
                if (int'(m_si) != int'(prev) + 1 || cyc != 1 + int'(m_si) * (settle + 1))
                    tim_ok = 1'b0;
            end
            prev = m_si;
        end
    endtask

    typedef struct {
        logic [W-1:0] key;
        logic [1:0]   mode;
        int           err;
        bit           fv;
        logic [W-1:0] fp;
        bit           kc;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int  dc, cnt, first;
        bit  ok, seen;
        logic [W-1:0] rk;

        rst_n = 1'b0; start = 1'b0; sel = 1'b0; mode = 2'd0; key = '0; fmap = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_results1", {busy1, done1, ec1, fv1, fp1, kc1}, 64'd0);
        chk("reset_stim1", {si1, sk1}, 64'd0);
        chk("reset_results2", {busy2, done2, ec2, fv2, fp2, kc2, si2, sk2}, 64'd0);
        rst_n = 1'b1;

        tbl[0] = '{8'hA5, 2'd0, 0,   1'b0, 8'h00, 1'b1};
        tbl[1] = '{8'h5A, 2'd0, 1,   1'b1, 8'h5A, 1'b0};
        tbl[2] = '{8'h00, 2'd1, 256, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{8'hFF, 2'd0, 1,   1'b1, 8'hFF, 1'b0};

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_sweep(tbl[i].key, 1, 1'b0, dc, ok);
            chk($sformatf("t%0d_done_cycle", i), dc, 513);
            chk($sformatf("t%0d_timing", i), ok, 1);
            chk($sformatf("t%0d_err_count", i), m_ec, tbl[i].err);
            chk($sformatf("t%0d_first_valid", i), m_fv, tbl[i].fv);
            chk($sformatf("t%0d_first_pat", i), m_fp, tbl[i].fp);
            chk($sformatf("t%0d_key_correct", i), m_kc, tbl[i].kc);
            @(negedge clk);
            chk($sformatf("t%0d_after_done", i), {m_done, m_busy, m_ec, m_kc},
                {1'b0, 1'b0, 9'(tbl[i].err), tbl[i].kc});
        end

        // Random mismatch maps scored by counting flipped patterns directly.
        mode = 2'd2;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 256; p++) fmap[p] = ($urandom_range(0, 15) == 0);
            if (r == 2) fmap = '0;
            cnt = 0; first = 0;
            for (int p = 255; p >= 0; p--) if (fmap[p]) begin cnt++; first = p; end
            rk = 8'($urandom);
            run_sweep(rk, 1, 1'b0, dc, ok);
            chk($sformatf("r%0d_done_cycle", r), dc, 513);
            chk($sformatf("r%0d_timing", r), ok, 1);
            chk($sformatf("r%0d_err_count", r), m_ec, cnt);
            chk($sformatf("r%0d_first_valid", r), m_fv, cnt != 0);
            chk($sformatf("r%0d_first_pat", r), m_fp, (cnt != 0) ? first : 0);
            chk($sformatf("r%0d_key_correct", r), m_kc, cnt == 0);
        end

        // Reset in the middle of a sweep.
        mode = 2'd0;
        @(negedge clk);
        key = 8'h5A; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (200) @(negedge clk);
        chk("abort_busy_before", busy1, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_results", {busy1, done1, ec1, fv1, fp1, kc1}, 64'd0);
        chk("abort_stim", {si1, sk1}, 64'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (done1 || busy1) seen = 1'b1;
        end
        chk("abort_no_done", seen, 0);

        // Start held high: one sweep, key held, re-accept right after done.
        run_sweep(8'hC3, 1, 1'b1, dc, ok);
        chk("hold_done_cycle", dc, 513);
        chk("hold_timing", ok, 1);
        chk("hold_err_count", m_ec, 1);
        chk("hold_first_pat", m_fp, 8'hC3);
        key = 8'h33;
        @(negedge clk);
        chk("hold_idle_gap", {m_busy, m_done}, 2'b00);
        @(negedge clk);
        chk("hold_reaccept", {m_busy, m_sk}, {1'b1, 8'h33});
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (m_done) begin seen = 1'b1; break; end
        end
        chk("hold_second_done", seen, 1);
        chk("hold_second_result", {m_ec, m_fv, m_fp, m_kc}, {9'd1, 1'b1, 8'h33, 1'b0});

        // Longer settle time on the second instance.
        sel = 1'b1;
        run_sweep(8'hA5, 3, 1'b0, dc, ok);
        chk("s3_done_cycle", dc, 1025);
        chk("s3_timing", ok, 1);
        chk("s3_result", {m_ec, m_fv, m_kc}, {9'd0, 1'b0, 1'b1});
        run_sweep(8'h12, 3, 1'b0, dc, ok);
        chk("s3b_done_cycle", dc, 1025);
        chk("s3b_result", {m_ec, m_fv, m_fp, m_kc}, {9'd1, 1'b1, 8'h12, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_sweep_evaluator.md
KEY_SWEEP_EVALUATOR -- requirements
Module: key_sweep_evaluator

Purpose: downstream checker for a locked netlist. It applies every input pattern with one candidate key to the locked design and the unlocked oracle, and counts output mismatches.

Interface
REQ-001 Parameter W, default 8: width of the input pattern and of the key; must be 2..16.
REQ-002 Parameter SETTLE, default 1: DRIVE cycles per pattern before sampling; must be ≥1.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 start  in  1  request a sweep; sampled only in IDLE.
REQ-006 key  in  W  candidate key; captured on accepted start.
REQ-007 locked_out  in  1  locked-design response to stim_inputs/stim_key.
REQ-008 golden_out  in  1  oracle response to stim_inputs.
REQ-009 stim_inputs  out  W  pattern driven to locked design and oracle.
REQ-010 stim_key  out  W  key driven to locked design.
REQ-011 busy  out  1  high while a sweep is in progress.
REQ-012 done  out  1  one-cycle pulse at sweep end.
REQ-013 err_count  out  W+1  number of mismatching patterns in the last sweep.
REQ-014 first_err_valid  out  1  at least one mismatch recorded.
REQ-015 first_err_pat  out  W  lowest pattern that mismatched.
REQ-016 key_correct  out  1  last completed sweep had zero mismatches.

Function
REQ-017 FSM states SHALL be IDLE, DRIVE, SAMPLE and DONE; all outputs SHALL be registered.
REQ-018 IDLE with start=1: capture key into stim_key, set stim_inputs=0, clear err_count, first_err_valid, first_err_pat and key_correct, and go to DRIVE next cycle.
REQ-019 IDLE with start=0: remain in IDLE and hold all result outputs.
REQ-020 DRIVE SHALL last exactly SETTLE cycles (settle counter), then go to SAMPLE.
REQ-021 SAMPLE SHALL compare locked_out with golden_out for one cycle. On mismatch, err_count increments by 1. If first_err_valid=0, it also sets first_err_valid=1 and first_err_pat=stim_inputs.
REQ-022 SAMPLE exit when stim_inputs < 2^W-1: increment stim_inputs and go to DRIVE.
REQ-023 SAMPLE exit when stim_inputs = 2^W-1: go to DONE; stim_inputs does not wrap.
REQ-024 DONE (one cycle): done=1, key_correct=(err_count==0), then go to IDLE.
REQ-025 stim_inputs and stim_key SHALL be stable from DRIVE entry through SAMPLE for each pattern.
REQ-026 busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and DONE.
REQ-027 start asserted while not in IDLE SHALL be ignored; it is not queued.
REQ-028 err_count SHALL reach at most 2^W without overflow; width W+1 is sufficient and no saturation logic is required.
REQ-029 Timing: start accepted at edge 0; DRIVE for pattern p begins at cycle 1+p*(SETTLE+1); done is high at cycle 1+2^W*(SETTLE+1).
REQ-030 Back-to-back sweeps: start asserted in the cycle after done SHALL be accepted.

Reset
REQ-031 rst_n=0 at any rising edge SHALL force IDLE.
REQ-032 The same reset SHALL clear stim_inputs, stim_key, busy, done, err_count, first_err_valid, first_err_pat, key_correct and the settle counter to 0.
REQ-033 Reset mid-sweep SHALL abort the sweep without a done pulse; partial results are discarded.

Verification
REQ-034 W=8, SETTLE=1; oracle model with locked model that flips output only when inputs==key and key≠0xA5. Sweep with key=0xA5 -> done at cycle 513, err_count=0, key_correct=1, first_err_valid=0.
REQ-035 Same models, key=0x5A -> err_count=1, first_err_valid=1, first_err_pat=0x5A, key_correct=0.
REQ-036 Locked model always inverted -> err_count=256, first_err_pat=0x00, key_correct=0.
REQ-037 Reset pulse at cycle 200 of a sweep -> next cycle shows busy=0, all outputs 0, and no done pulse for that sweep.
REQ-038 start held high for a whole sweep -> exactly one sweep; the next sweep is accepted the cycle after done. stim_key stays at the first captured key throughout the first sweep, even if key changes mid-sweep.
REQ-039 SETTLE=3 -> done at cycle 1025; stim_inputs changes only on SAMPLE→DRIVE transitions.
